scene_renderer: RTL and testbench

- Display-side consumer of the game core's outputs: `gpu_en`, `dino_y`, `obstacle_x` and `state`.
- Snapshots the scene at each frame start, then rasterises a monochrome H_RES x V_RES frame: ground line, dinosaur box, obstacle box.
- Streams one pixel per transfer to the panel driver over a valid/ready handshake, row-major from (0,0).
- Sits between the game core and the display driver.

---
 rtl/scene_renderer.sv | 161 ++++++++++++++++
 tb/tb_scene_renderer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/scene_renderer.sv
// scene_renderer: snapshots game state per frame, streams a monochrome raster.
// Optional game-over inversion: define SCENE_RENDERER_GAMEOVER_INVERT_EN.
module scene_renderer #(
    parameter int H_RES      = 256,
    parameter int V_RES      = 64,
    parameter int GROUND_ROW = 56,
    parameter int DINO_X     = 16,
    parameter int DINO_W     = 16,
    parameter int DINO_H     = 20,
    parameter int OBS_W      = 16,
    parameter int OBS_H      = 26,
    parameter int XW         = $clog2(H_RES),
    parameter int YW         = $clog2(V_RES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          gpu_en,
    input  logic [15:0]   dino_y,
    input  logic [15:0]   obstacle_x,
    input  logic [1:0]    state,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic          pix_data,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic          frame_done,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LATCH,
        S_SCAN,
        S_DONE
    } state_t;

    state_t        r_st;
    state_t        w_nst;
    logic [15:0]   r_dy;
    logic [15:0]   r_ox;
    logic [1:0]    r_gs;
    logic [XW-1:0] r_x;
    logic [XW-1:0] w_nx;
    logic [YW-1:0] r_y;
    logic [YW-1:0] w_ny;
    logic          r_valid;
    logic          r_data;
    logic          w_xfer;
    logic          w_last;
    logic          w_eol;

    // 17-bit arithmetic keeps ox+OBS_W from wrapping at the right edge
    function automatic logic f_pix(
        input logic [XW-1:0] x,
        input logic [YW-1:0] y,
        input logic [15:0]   dy,
        input logic [15:0]   ox,
        input logic [1:0]    gs
    );
        logic [16:0] w_x;
        logic [16:0] w_y;
        logic [16:0] w_dyc;
        logic [16:0] w_bot;
        logic [16:0] w_top;
        logic [16:0] w_ox;
        logic        w_gnd;
        logic        w_dino;
        logic        w_obs;
        logic        w_lit;
        w_x   = 17'(x);
        w_y   = 17'(y);
        w_ox  = {1'b0, ox};
        w_dyc = (dy > 16'(GROUND_ROW - DINO_H)) ?
                17'(GROUND_ROW - DINO_H) : {1'b0, dy};
        w_bot = 17'(GROUND_ROW) - w_dyc;
        w_top = w_bot - 17'(DINO_H);
        w_gnd = (w_y == 17'(GROUND_ROW));
        w_dino = (w_x >= 17'(DINO_X)) &&
                 (w_x < 17'(DINO_X + DINO_W)) &&
                 (w_y >= w_top) && (w_y < w_bot);
        w_obs = (gs != 2'd0) &&
                (w_x >= w_ox) && (w_x < w_ox + 17'(OBS_W)) &&
                (w_y >= 17'(GROUND_ROW - OBS_H)) &&
                (w_y < 17'(GROUND_ROW));
        w_lit = w_gnd || w_dino || w_obs;
`ifdef SCENE_RENDERER_GAMEOVER_INVERT_EN
        if (gs == 2'd3) w_lit = !w_lit;
`endif
        return w_lit;
    endfunction

    always_comb begin
        w_xfer = r_valid && pix_ready;
        w_eol  = (r_x == XW'(H_RES - 1));
        w_last = w_eol && (r_y == YW'(V_RES - 1));
        w_nx   = w_eol ? '0 : r_x + 1'b1;
        w_ny   = w_eol ? r_y + 1'b1 : r_y;
    end

    always_comb begin
        w_nst = r_st;
        unique case (r_st)
            S_IDLE:  if (gpu_en) w_nst = S_LATCH;
            S_LATCH: w_nst = S_SCAN;
            S_SCAN:  if (w_xfer && w_last) w_nst = S_DONE;
            S_DONE:  w_nst = gpu_en ? S_LATCH : S_IDLE;
            default: w_nst = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_st <= S_IDLE;
        else      r_st <= w_nst;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dy    <= '0;
            r_ox    <= '0;
            r_gs    <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_valid <= 1'b0;
            r_data  <= 1'b0;
        end else begin
            case (r_st)
                S_LATCH: begin
                    r_dy    <= dino_y;
                    r_ox    <= obstacle_x;
                    r_gs    <= state;
                    r_x     <= '0;
                    r_y     <= '0;
                    r_valid <= 1'b1;
                    r_data  <= f_pix('0, '0, dino_y,
                                     obstacle_x, state);
                end
                S_SCAN: begin
                    if (w_xfer) begin
                        if (w_last) begin
                            r_valid <= 1'b0;
                        end else begin
                            r_x    <= w_nx;
                            r_y    <= w_ny;
                            r_data <= f_pix(w_nx, w_ny, r_dy,
                                            r_ox, r_gs);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign pix_valid  = r_valid;
    assign pix_data   = r_data;
    assign pix_x      = r_x;
    assign pix_y      = r_y;
    assign frame_done = (r_st == S_DONE);
    assign busy       = (r_st == S_LATCH) || (r_st == S_SCAN);

endmodule

// File: tb/tb_scene_renderer.sv
// tb_scene_renderer: directed frames with random backpressure,
// checked against a coordinate-level scene model.
module tb_scene_renderer;

    localparam int NPIX = 256 * 64;
`ifdef SCENE_RENDERER_GAMEOVER_INVERT_EN
    localparam bit INV = 1'b1;
`else
    localparam bit INV = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        gpu_en;
    logic [15:0] dino_y;
    logic [15:0] obstacle_x;
    logic [1:0]  state;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_data;
    logic [7:0]  pix_x;
    logic [5:0]  pix_y;
    logic        frame_done;
    logic        busy;

    int total;
    int bad;
    bit frm [64][256];

    scene_renderer dut (
        .clk        (clk),
        .rst        (rst),
        .gpu_en     (gpu_en),
        .dino_y     (dino_y),
        .obstacle_x (obstacle_x),
        .state      (state),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .frame_done (frame_done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d",
                   tag, obs, exp);
        end
    endtask

    // Scene as drawn on screen: ground, clamped dino, obstacle
    function automatic bit model_pix(int x, int y, int dy,
                                     int ox, int gs);
        int  d;
        bit  lit;
        d   = (dy > 36) ? 36 : dy;
        lit = (y == 56);
        if (x >= 16 && x < 32 && y >= 36 - d && y < 56 - d)
            lit = 1'b1;
        if (gs != 0 && x >= ox && x < ox + 16 && y >= 30 && y < 56)
            lit = 1'b1;
        if (INV && gs == 3) lit = !lit;
        return lit;
    endfunction

    function automatic int rowcnt(int r);
        int n;
        n = 0;
        for (int c = 0; c < 256; c++) n += int'(frm[r][c]);
        return n;
    endfunction

    task automatic start_check(input string tag);
        @(negedge clk);
        chk({tag, "_latch_busy"}, busy, 1);
        chk({tag, "_latch_valid"}, pix_valid, 0);
        @(negedge clk);
        chk({tag, "_first_valid"}, pix_valid, 1);
        chk({tag, "_first_xy"}, {pix_x, 2'b0, pix_y}, 0);
    endtask

    task automatic run_frame(input string tag, input int pct,
                             input int chg_at, input int new_ox,
                             input int drop_at, input int sdy,
                             input int sox, input int sgs);
        int k, cyc, perr, cerr, serr;
        logic pv, pd, stall;
        logic [7:0] px;
        logic [5:0] py;
        k = 0; cyc = 0; perr = 0; cerr = 0; serr = 0;
        stall = 1'b0; pv = 1'b0; pd = 1'b0; px = '0; py = '0;
        while (k < NPIX && cyc < 60000) begin
            if (stall && (pix_valid !== pv || pix_data !== pd ||
                          pix_x !== px || pix_y !== py))
                serr++;
            pix_ready = ($urandom_range(0, 99) < pct);
            if (pix_valid === 1'b1 && pix_ready) begin
                if (pix_x !== 8'(k % 256) || pix_y !== 6'(k / 256))
                    cerr++;
                if (pix_data !== model_pix(k % 256, k / 256,
                                           sdy, sox, sgs))
                    perr++;
                frm[k / 256][k % 256] = pix_data;
                k++;
                if (k == chg_at) obstacle_x = 16'(new_ox);
                if (k == drop_at) gpu_en = 1'b0;
            end
            stall = (pix_valid === 1'b1) && !pix_ready;
            pv = pix_valid; pd = pix_data;
            px = pix_x; py = pix_y;
            @(negedge clk);
            cyc++;
        end
        pix_ready = 1'b1;
        chk({tag, "_xfers"}, k, NPIX);
        chk({tag, "_coord_errs"}, cerr, 0);
        chk({tag, "_pixel_errs"}, perr, 0);
        chk({tag, "_stall_errs"}, serr, 0);
        chk({tag, "_frame_done"}, frame_done, 1);
        chk({tag, "_done_valid"}, pix_valid, 0);
        chk({tag, "_done_busy"}, busy, 0);
    endtask

    initial begin
        int  nbad;
        bit  found;
        total = 0; bad = 0;
        rst = 1'b0; gpu_en = 1'b0; pix_ready = 1'b0;
        dino_y = '0; obstacle_x = '0; state = '0;
        repeat (3) @(negedge clk);
        chk("rst_outputs", {pix_valid, pix_data, pix_x, pix_y,
                            frame_done, busy}, 0);

        // Async reset in the middle of a scan
        rst = 1'b1; gpu_en = 1'b1; pix_ready = 1'b1;
        obstacle_x = 16'd100; state = 2'd1;
        found = 1'b0;
        for (int i = 0; i < 4000 && !found; i++) begin
            @(negedge clk);
            if (pix_valid && pix_x == 8'd37 && pix_y == 6'd10)
                found = 1'b1;
        end
        chk("reach_37_10", found, 1);
        #1 rst = 1'b0;
        #1;
        chk("async_rst_valid", pix_valid, 0);
        chk("async_rst_xy", {pix_x, 2'b0, pix_y}, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", frame_done, 0);
        @(negedge clk);
        rst = 1'b1;
        start_check("f1");

        // Static scene; obstacle_x changes mid-frame
        run_frame("f1", 100, 5000, 60, -1, 0, 100, 1);
        nbad = 0;
        for (int r = 0; r < 64; r++) begin
            int e;
            e = (r == 56) ? 256 : (r >= 36 && r < 56) ? 32 :
                (r >= 30 && r < 36) ? 16 : 0;
            if (rowcnt(r) != e) nbad++;
        end
        chk("f1_bad_rows", nbad, 0);
        chk("f1_row56", rowcnt(56), 256);
        chk("f1_obs_100", frm[40][100], 1);
        chk("f1_obs_60", frm[40][60], 0);

        // Next frame uses new snapshot; gpu_en drops mid-frame
        dino_y = 16'd500; state = 2'd2;
        start_check("f2");
        run_frame("f2", 100, -1, 0, 8000, 500, 60, 2);
        chk("f2_row0", rowcnt(0), 16);
        chk("f2_row19", rowcnt(19), 16);
        chk("f2_row20", rowcnt(20), 0);
        chk("f2_obs_60", frm[40][60], 1);
        chk("f2_obs_75", frm[40][75], 1);
        chk("f2_obs_76", frm[40][76], 0);
        chk("f2_obs_100", frm[40][100], 0);
        @(negedge clk);
        chk("f2_idle_busy", busy, 0);
        chk("f2_idle_done", frame_done, 0);
        repeat (3) @(negedge clk);
        chk("f2_idle_stay", {busy, pix_valid}, 0);

        // Backpressure, right-edge clip, game-over state
        dino_y = 16'd36; obstacle_x = 16'd250; state = 2'd3;
        gpu_en = 1'b1;
        start_check("f3");
        run_frame("f3", 50, -1, 0, -1, 36, 250, 3);
        chk("f3_row56", rowcnt(56), INV ? 0 : 256);
        chk("f3_px00", frm[0][0], INV);
        chk("f3_row40", rowcnt(40), INV ? 250 : 6);
        chk("f3_clip_255", frm[40][255], !INV);
        chk("f3_nowrap_0", frm[40][0], INV);
        chk("f3_nowrap_9", frm[40][9], INV);
        chk("f3_dino_top", frm[0][16], !INV);

        // Obstacle beyond the screen
        dino_y = 16'd10; obstacle_x = 16'd300; state = 2'd1;
        start_check("f4");
        run_frame("f4", 100, -1, 0, -1, 10, 300, 1);
        gpu_en = 1'b0;
        chk("f4_row40", rowcnt(40), 16);
        chk("f4_row30", rowcnt(30), 16);
        chk("f4_row25", rowcnt(25), 0);
        chk("f4_no_alias", frm[40][44], 0);
        @(negedge clk);
        chk("f4_idle_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
